// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the instruction fetch unit and its surroundings
// (program loader on one side, Control_Unit on the other).
//
// Handshake: NEXT is a one-cycle completion pulse from Control_Unit and
// is only acted on while INSTR_VALID=1. INSTR and PC stay stable from
// the cycle INSTR_VALID rises until the edge that samples NEXT=1.
// LOAD_EN writes LOAD_DATA to LOAD_ADDR in the same edge, but only while
// the unit is stopped.
//
// Signals:
//   LOAD_EN / LOAD_ADDR / LOAD_DATA  memory load port (master -> slave)
//   START                            run from address 0 (master -> slave)
//   NEXT                             instruction done (master -> slave)
//   INSTR / INSTR_VALID / PC         current instruction (slave -> master)
//   ONSWT / OFFSWT                   run level / stop pulse (slave -> master)
//   HALTED / LOAD_ERR                status (slave -> master)
//   STATE_DBG                        FSM state for observation (slave -> master)
interface instr_fetch_unit_if #(
  parameter int IMEM_DEPTH = 32,
  parameter int INSTR_W    = 32
);
  localparam int LogD = $clog2(IMEM_DEPTH);

  logic               LOAD_EN;
  logic [LogD-1:0]    LOAD_ADDR;
  logic [INSTR_W-1:0] LOAD_DATA;
  logic               START;
  logic               NEXT;
  logic [INSTR_W-1:0] INSTR;
  logic               INSTR_VALID;
  logic [LogD-1:0]    PC;
  logic               ONSWT;
  logic               OFFSWT;
  logic               HALTED;
  logic               LOAD_ERR;
  logic [1:0]         STATE_DBG;

  modport master (
    output LOAD_EN, LOAD_ADDR, LOAD_DATA, START, NEXT,
    input  INSTR, INSTR_VALID, PC, ONSWT, OFFSWT, HALTED, LOAD_ERR, STATE_DBG
  );

  modport slave (
    input  LOAD_EN, LOAD_ADDR, LOAD_DATA, START, NEXT,
    output INSTR, INSTR_VALID, PC, ONSWT, OFFSWT, HALTED, LOAD_ERR, STATE_DBG
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage feeding Control_Unit. Holds a loadable
// instruction memory and a program counter, presents one instruction at
// a time and advances on NEXT. Generates the ONSWT run level and the
// one-cycle OFFSWT stop pulse.
//
// Ports:
//   CLK   clock, rising edge
//   RSTN  asynchronous reset, active-high (despite the name)
//   bus   instr_fetch_unit_if.slave (load port, START/NEXT, instruction
//         outputs, status, STATE_DBG)
//
// Optional build macro FETCH_PREFETCH_EN: while an instruction is issued
// the following word is pre-read so NEXT advances with no bubble cycle.
// Without it, every NEXT goes through one FETCH bubble.
//
// A word with bit 7 set is the halt opcode; it is never issued.
module instr_fetch_unit #(
  parameter int IMEM_DEPTH = 32,
  parameter int INSTR_W    = 32
) (
  input logic              CLK,
  input logic              RSTN,
  instr_fetch_unit_if.slave bus
);
  localparam int LogD = $clog2(IMEM_DEPTH);
  localparam logic [LogD-1:0] LastPc = LogD'(IMEM_DEPTH - 1);
  localparam logic [LogD-1:0] One    = LogD'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e             state_q;
  logic [LogD-1:0]    pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic               valid_q;
  logic               onswt_q;
  logic               offswt_q;
  logic               halted_q;
  logic               load_err_q;

  logic [INSTR_W-1:0] mem [IMEM_DEPTH];
  logic [INSTR_W-1:0] rd_q;
  logic [LogD-1:0]    rd_addr;

  logic stopped;
  logic load_ok;
  logic start_ok;
  logic next_ok;
  logic at_end;

  assign stopped  = (state_q == S_IDLE) || (state_q == S_HALT);
  assign load_ok  = stopped && bus.LOAD_EN;
  // A load in the same cycle wins over START.
  assign start_ok = stopped && bus.START && !bus.LOAD_EN;
  assign next_ok  = (state_q == S_ISSUE) && bus.NEXT;
  assign at_end   = (pc_q == LastPc);

  // Read address is chosen so rd_q holds the word the FSM needs in the
  // following cycle: mem[PC] in FETCH, and with prefetch mem[PC+1] in ISSUE.
  always_comb begin
    rd_addr = pc_q;
    if (start_ok) begin
      rd_addr = '0;
`ifdef FETCH_PREFETCH_EN
    end else if (state_q == S_FETCH) begin
      rd_addr = pc_q + One;
    end else if (state_q == S_ISSUE) begin
      rd_addr = next_ok ? (pc_q + One + One) : (pc_q + One);
`else
    end else if (next_ok) begin
      rd_addr = pc_q + One;
`endif
    end
  end

  // Instruction memory: not reset, contents survive RSTN.
  always_ff @(posedge CLK) begin
    if (load_ok) begin
      mem[bus.LOAD_ADDR] <= bus.LOAD_DATA;
    end
    rd_q <= mem[rd_addr];
  end

  always_ff @(posedge CLK or posedge RSTN) begin
    if (RSTN) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      onswt_q    <= 1'b0;
      offswt_q   <= 1'b0;
      halted_q   <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      offswt_q <= 1'b0;
      // Loads while running are dropped but remembered until START/reset.
      if (bus.LOAD_EN && !stopped) begin
        load_err_q <= 1'b1;
      end
      case (state_q)
        S_IDLE, S_HALT: begin
          if (start_ok) begin
            state_q    <= S_FETCH;
            pc_q       <= '0;
            halted_q   <= 1'b0;
            load_err_q <= 1'b0;
            onswt_q    <= 1'b1;
          end
        end
        S_FETCH: begin
          if (rd_q[7]) begin
            state_q  <= S_HALT;
            valid_q  <= 1'b0;
            offswt_q <= 1'b1;
            onswt_q  <= 1'b0;
            halted_q <= 1'b1;
          end else begin
            state_q <= S_ISSUE;
            instr_q <= rd_q;
            valid_q <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (bus.NEXT) begin
`ifdef FETCH_PREFETCH_EN
            if (at_end || rd_q[7]) begin
`else
            if (at_end) begin
`endif
              state_q  <= S_HALT;
              valid_q  <= 1'b0;
              offswt_q <= 1'b1;
              onswt_q  <= 1'b0;
              halted_q <= 1'b1;
            end else begin
              pc_q <= pc_q + One;
`ifdef FETCH_PREFETCH_EN
              instr_q <= rd_q;
`else
              valid_q <= 1'b0;
              state_q <= S_FETCH;
`endif
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.INSTR       = instr_q;
  assign bus.INSTR_VALID = valid_q;
  assign bus.PC          = pc_q;
  assign bus.ONSWT       = onswt_q;
  assign bus.OFFSWT      = offswt_q;
  assign bus.HALTED      = halted_q;
  assign bus.LOAD_ERR    = load_err_q;
  assign bus.STATE_DBG   = state_q;
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch stage directly upstream of Control_Unit in the SIMD matrix engine. It holds a loadable instruction memory and a program counter. It presents one 32-bit instruction at a time on INSTR and advances when the Control_Unit signals completion. It also generates the ONSWT and OFFSWT run/stop strobes that Control_Unit consumes.

Parameters:
IMEM_DEPTH, 32, number of 32-bit instruction words
INSTR_W, 32, instruction width (must match Control_Unit INSTR)
LogD, $clog2(IMEM_DEPTH), PC / load address width

Ports:
CLK  in  1  clock, rising edge
RSTN  in  1  asynchronous reset, active-high
LOAD_EN  in  1  write LOAD_DATA into memory at LOAD_ADDR this cycle
LOAD_ADDR  in  LogD  memory write address
LOAD_DATA  in  INSTR_W  memory write data
START  in  1  begin execution from address 0
NEXT  in  1  Control_Unit finished current instruction; 1-cycle pulse
INSTR  out  INSTR_W  current instruction to Control_Unit
INSTR_VALID  out  1  INSTR holds a live instruction
PC  out  LogD  address of the instruction on INSTR
ONSWT  out  1  run level to Control_Unit
OFFSWT  out  1  one-cycle stop pulse to Control_Unit
HALTED  out  1  program ended (halt word or end of memory)
LOAD_ERR  out  1  sticky: LOAD_EN seen while running

Behaviour:
- Reset (async, RSTN=1): state IDLE; INSTR=0, INSTR_VALID=0, PC=0, ONSWT=0, OFFSWT=0, HALTED=0, LOAD_ERR=0. The memory array is not reset and keeps its contents.
- Memory: synchronous write on LOAD_EN, accepted only in IDLE/HALT. Synchronous read with 1-cycle latency.
- IDLE: outputs quiet.
  - START=1 and LOAD_EN=0 -> PC<=0, HALTED<=0, LOAD_ERR<=0, ONSWT<=1, go FETCH.
  - START with LOAD_EN in the same cycle: the load takes priority; START is ignored.
- FETCH (1 cycle): read mem[PC].
  - Word bit7=1 is the halt opcode (0x80). Go HALT: INSTR_VALID stays 0, OFFSWT=1 for exactly one cycle, ONSWT<=0, HALTED<=1. The halt word is never issued.
  - Otherwise INSTR<=word, INSTR_VALID<=1, go ISSUE.
- ISSUE: INSTR and PC are held stable until NEXT=1.
  - On NEXT with PC==IMEM_DEPTH-1: go HALT as for a halt word. There is no wrap-around.
  - Otherwise: PC<=PC+1, INSTR_VALID<=0, go FETCH. This gives one bubble cycle; a new INSTR is valid 2 cycles after the NEXT edge.
- HALT: HALTED=1, ONSWT=0. LOAD_EN accepted. START restarts exactly as from IDLE.
- NEXT outside ISSUE: ignored. START outside IDLE/HALT: ignored.
- LOAD_EN in FETCH/ISSUE: write dropped, LOAD_ERR<=1. LOAD_ERR is cleared only by START or reset.
- Reset asserted mid-program: immediate return to IDLE with all outputs at reset values. No OFFSWT pulse is generated.

Optional Feature:
Macro FETCH_PREFETCH_EN.
- Defined:
  - During ISSUE, mem[PC+1] is pre-read.
  - On NEXT, INSTR<=prefetched word and PC<=PC+1 in the same edge. INSTR_VALID stays 1 with zero bubble.
  - Halt/end-of-memory checks apply to the prefetched word, and INSTR_VALID drops the cycle after NEXT.
  - A LOAD cannot occur while running, so the prefetch is never stale.
- Undefined: the one-bubble FETCH sequence above.

Test Plan:
- Reset mid-ISSUE (PC=3): RSTN=1 for 1 cycle -> INSTR_VALID=0, PC=0, ONSWT=0, OFFSWT stays 0; memory word 3 still readable after restart.
- Load mem[0..3]={0x01,0x09,0x02,0x80}, START -> INSTR 0x01 valid 2 cycles after START. Each NEXT pulse advances to 0x09, then 0x02 (PC 0,1,2). The NEXT after 0x02 produces OFFSWT for one cycle, HALTED=1, and 0x80 is never valid.
- Hold NEXT=0 for 10 cycles in ISSUE -> INSTR=0x09 and PC=1 unchanged, INSTR_VALID=1 throughout.
- Fill all 32 words with 0x03, START, 32 NEXT pulses -> PC reaches 31 and the 32nd NEXT halts with OFFSWT; PC never wraps to 0.
- LOAD_EN with LOAD_ADDR=5 while running -> mem[5] unchanged, LOAD_ERR=1. A following START clears LOAD_ERR. START with LOAD_EN together in IDLE -> write done, no start.
- FETCH_PREFETCH_EN defined, program {0x01,0x02,0x03,0x80}: back-to-back NEXT every cycle -> INSTR changes every cycle with INSTR_VALID never low; OFFSWT one cycle after the NEXT on 0x03.
